// File: rtl/rr_grant_pkg.sv
// Shared types and sizing for the rr_grant_sel round-robin arbiter.
package rr_grant_pkg;

  localparam int unsigned N_REQ      = 8;
  localparam int unsigned IDX_W      = $clog2(N_REQ);
  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} rr_state_e;

  typedef logic [IDX_W-1:0]      idx_t;
  typedef logic [N_REQ-1:0]      req_t;
  typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

endpackage

// File: rtl/rr_grant_sel_if.sv
// Request/grant bundle between requesters, the arbiter and the grant consumer.
// RR_GRANT_MASK_EN adds the req_mask input.
interface rr_grant_sel_if;
  import rr_grant_pkg::*;

  req_t req;
  logic gnt_ready;
  logic lock;
  idx_t gnt_idx;
  logic gnt_valid;
  logic gnt_locked;
  logic lock_timeout;
`ifdef RR_GRANT_MASK_EN
  req_t req_mask;

  modport master (input req, req_mask, gnt_ready, lock,
                  output gnt_idx, gnt_valid, gnt_locked, lock_timeout);
  modport slave  (output req, req_mask, gnt_ready, lock,
                  input gnt_idx, gnt_valid, gnt_locked, lock_timeout);
`else
  modport master (input req, gnt_ready, lock,
                  output gnt_idx, gnt_valid, gnt_locked, lock_timeout);
  modport slave  (output req, gnt_ready, lock,
                  input gnt_idx, gnt_valid, gnt_locked, lock_timeout);
`endif

endinterface

// File: rtl/rr_pick.sv
// Wrap-around first-set finder: lowest set bit at or above ptr, wrapping 7 -> 0.
module rr_pick
  import rr_grant_pkg::*;
(
  input  req_t req,
  input  idx_t ptr,
  output idx_t winner,
  output logic any
);

  // Scan from farthest to nearest so the closest set bit to ptr overwrites last.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (req[IDX_W'(ptr + IDX_W'(i))]) winner = IDX_W'(ptr + IDX_W'(i));
    end
  end

endmodule

// File: rtl/rr_grant_sel.sv
// Round-robin arbiter with valid/ready offer, optional lock/hold and lock watchdog.
// Optional build macro RR_GRANT_MASK_EN masks requesters during arbitration.
module rr_grant_sel
  import rr_grant_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_grant_sel_if.master bus
);

  localparam lock_cnt_t LOCK_LIMIT = LOCK_CNT_W'(MAX_LOCK);

  rr_state_e state_q, state_d;
  idx_t      ptr_q, ptr_d;
  lock_cnt_t lock_cnt_q, lock_cnt_d;
  idx_t      gnt_idx_q, gnt_idx_d;
  logic      gnt_valid_q, gnt_valid_d;
  logic      gnt_locked_q, gnt_locked_d;
  logic      lock_timeout_q, lock_timeout_d;

  req_t      eff_req;
  idx_t      winner;
  logic      any;

`ifdef RR_GRANT_MASK_EN
  assign eff_req = bus.req & ~bus.req_mask;
`else
  assign eff_req = bus.req;
`endif

  rr_pick u_pick (
    .req    (eff_req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      lock_cnt_q     <= '0;
      gnt_idx_q      <= '0;
      gnt_valid_q    <= 1'b0;
      gnt_locked_q   <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      lock_cnt_q     <= lock_cnt_d;
      gnt_idx_q      <= gnt_idx_d;
      gnt_valid_q    <= gnt_valid_d;
      gnt_locked_q   <= gnt_locked_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  // Priority only rotates on accept; gnt_idx holds its last value outside OFFER/HOLD.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    lock_cnt_d     = lock_cnt_q;
    gnt_idx_d      = gnt_idx_q;
    gnt_valid_d    = gnt_valid_q;
    gnt_locked_d   = gnt_locked_q;
    lock_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (bus.gnt_ready) begin
          ptr_d       = IDX_W'(gnt_idx_q + IDX_W'(1));
          gnt_valid_d = 1'b0;
          if (bus.lock) begin
            state_d      = HOLD;
            gnt_locked_d = 1'b1;
            lock_cnt_d   = LOCK_CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (lock_cnt_q != '1) lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        if (!bus.lock) begin
          state_d      = IDLE;
          gnt_locked_d = 1'b0;
        end else if (lock_cnt_q == LOCK_LIMIT) begin
          state_d        = IDLE;
          gnt_locked_d   = 1'b0;
          lock_timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_idx      = gnt_idx_q;
  assign bus.gnt_valid    = gnt_valid_q;
  assign bus.gnt_locked   = gnt_locked_q;
  assign bus.lock_timeout = lock_timeout_q;

  // Handshake inputs must be known whenever a grant is outstanding.
  a_no_x_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> !$isunknown({bus.req, bus.gnt_ready}));

endmodule
